// File: rtl/trap_unit.sv
// trap_unit: machine-mode trap controller with a small CSR file and a valid/ready redirect port.
// Optional feature VECTORED_IRQ_EN: vectored interrupt targets when mtvec[0] is set.
//
// state      | meaning
// S_IDLE     | watching commit for exception, mret or interrupt
// S_REDIRECT | redirect_valid/target held until redirect_ready
module trap_unit #(
    parameter int XLEN    = 32,
    parameter int NUM_IRQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pipe_flush,
    input  logic               exc_valid,
    input  logic [4:0]         exc_cause,
    input  logic [XLEN-1:0]    exc_pc,
    input  logic               commit_valid,
    input  logic [XLEN-1:0]    commit_pc,
    input  logic               mret,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               csr_we,
    input  logic [11:0]        csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    output logic               redirect_valid,
    input  logic               redirect_ready,
    output logic [XLEN-1:0]    redirect_target,
    output logic               trap_busy
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_REDIRECT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic               st_mie;
    logic               st_mpie;
    logic [NUM_IRQ-1:0] mie_q;
    logic [XLEN-1:0]    mtvec_q;
    logic [XLEN-1:0]    mepc_q;
    logic [XLEN-1:0]    mcause_q;

    logic [NUM_IRQ-1:0] pending;
    logic [3:0]         irq_idx;
    logic [4:0]         irq_cause;
    logic               irq_take;
    logic               can_accept;
    logic               take_exc;
    logic               take_mret;
    logic               take_irq;
    logic               take_any;
    logic [XLEN-1:0]    trap_base;
    logic [XLEN-1:0]    irq_target;
    logic [XLEN-1:0]    target_d;
    logic [XLEN-1:0]    mtvec_wdata;

    // Lowest-index pending line wins; scanning downward lets the lowest hit land last.
    always_comb begin
        pending = irq & mie_q;
        irq_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) irq_idx = 4'(i);
        end
        irq_cause = 5'd16 + {1'b0, irq_idx};
        irq_take  = commit_valid & st_mie & (|pending) & ~exc_valid & ~mret;
    end

    always_comb begin
        trap_base = {mtvec_q[XLEN-1:2], 2'b00};
`ifdef VECTORED_IRQ_EN
        irq_target  = mtvec_q[0] ? (trap_base + (XLEN'(irq_cause) << 2)) : trap_base;
        mtvec_wdata = {csr_wdata[XLEN-1:2], 1'b0, csr_wdata[0]};
`else
        irq_target  = trap_base;
        mtvec_wdata = {csr_wdata[XLEN-1:2], 2'b00};
`endif
    end

    always_comb begin
        state_d    = state_q;
        can_accept = (state_q == S_IDLE) & ~pipe_flush;
        take_exc   = can_accept & exc_valid;
        take_mret  = can_accept & mret & ~exc_valid;
        take_irq   = can_accept & irq_take;
        take_any   = take_exc | take_mret | take_irq;
        if (take_exc)       target_d = trap_base;
        else if (take_mret) target_d = mepc_q;
        else                target_d = irq_target;

        case (state_q)
            S_IDLE:     if (take_any) state_d = S_REDIRECT;
            S_REDIRECT: if (redirect_ready) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            redirect_target <= '0;
        end else begin
            state_q <= state_d;
            if (take_any) redirect_target <= target_d;
        end
    end

    // Trap/mret updates are placed after the CSR write so they override it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_mie   <= 1'b0;
            st_mpie  <= 1'b0;
            mie_q    <= '0;
            mtvec_q  <= '0;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            if (csr_we) begin
                case (csr_addr)
                    ADDR_MSTATUS: begin
                        st_mie  <= csr_wdata[3];
                        st_mpie <= csr_wdata[7];
                    end
                    ADDR_MIE:    mie_q    <= csr_wdata[NUM_IRQ-1:0];
                    ADDR_MTVEC:  mtvec_q  <= mtvec_wdata;
                    ADDR_MEPC:   mepc_q   <= {csr_wdata[XLEN-1:2], 2'b00};
                    ADDR_MCAUSE: mcause_q <= csr_wdata;
                    default: ;
                endcase
            end
            if (take_exc) begin
                mepc_q   <= exc_pc;
                mcause_q <= {{(XLEN-5){1'b0}}, exc_cause};
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
            end else if (take_irq) begin
                mepc_q   <= commit_pc;
                mcause_q <= {1'b1, {(XLEN-6){1'b0}}, irq_cause};
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
            end else if (take_mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            ADDR_MSTATUS: begin
                csr_rdata[3] = st_mie;
                csr_rdata[7] = st_mpie;
            end
            ADDR_MIE:    csr_rdata = XLEN'(mie_q);
            ADDR_MTVEC:  csr_rdata = mtvec_q;
            ADDR_MEPC:   csr_rdata = mepc_q;
            ADDR_MCAUSE: csr_rdata = mcause_q;
            default:     csr_rdata = '0;
        endcase
    end

    assign redirect_valid = (state_q == S_REDIRECT);
    assign trap_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_trap_unit.sv
// Self-checking bench for trap_unit: directed scenarios then randomized cycles against a reference model.
`timescale 1ns/1ps
module tb_trap_unit;
    localparam int XLEN    = 32;
    localparam int NUM_IRQ = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               pipe_flush;
    logic               exc_valid;
    logic [4:0]         exc_cause;
    logic [XLEN-1:0]    exc_pc;
    logic               commit_valid;
    logic [XLEN-1:0]    commit_pc;
    logic               mret;
    logic [NUM_IRQ-1:0] irq;
    logic               csr_we;
    logic [11:0]        csr_addr;
    logic [XLEN-1:0]    csr_wdata;
    logic [XLEN-1:0]    csr_rdata;
    logic               redirect_valid;
    logic               redirect_ready;
    logic [XLEN-1:0]    redirect_target;
    logic               trap_busy;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic        m_busy;
    logic [31:0] m_tgt;
    logic        m_mie;
    logic        m_mpie;
    logic [3:0]  m_mie_reg;
    logic [31:0] m_mtvec;
    logic [31:0] m_mepc;
    logic [31:0] m_mcause;

    trap_unit #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) dut (
        .clk             (clk),
        .rst             (rst),
        .pipe_flush      (pipe_flush),
        .exc_valid       (exc_valid),
        .exc_cause       (exc_cause),
        .exc_pc          (exc_pc),
        .commit_valid    (commit_valid),
        .commit_pc       (commit_pc),
        .mret            (mret),
        .irq             (irq),
        .csr_we          (csr_we),
        .csr_addr        (csr_addr),
        .csr_wdata       (csr_wdata),
        .csr_rdata       (csr_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_ready  (redirect_ready),
        .redirect_target (redirect_target),
        .trap_busy       (trap_busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_tgt = '0; m_mie = 1'b0; m_mpie = 1'b0;
        m_mie_reg = '0; m_mtvec = '0; m_mepc = '0; m_mcause = '0;
    endtask

    task automatic clear_inputs();
        pipe_flush = 0; exc_valid = 0; exc_cause = '0; exc_pc = '0;
        commit_valid = 0; commit_pc = '0; mret = 0; irq = '0;
        csr_we = 0; csr_addr = '0; csr_wdata = '0;
    endtask

    // Next architectural state from the current inputs, using the old CSR values for decisions.
    task automatic model_step();
        logic        n_busy, n_mie, n_mpie;
        logic [31:0] n_tgt, n_mtvec, n_mepc, n_mcause;
        logic [3:0]  n_mie_reg, pend;
        int          idx;
        n_busy = m_busy; n_tgt = m_tgt; n_mie = m_mie; n_mpie = m_mpie;
        n_mie_reg = m_mie_reg; n_mtvec = m_mtvec; n_mepc = m_mepc; n_mcause = m_mcause;
        if (csr_we) begin
            case (csr_addr)
                12'h300: begin n_mie = csr_wdata[3]; n_mpie = csr_wdata[7]; end
                12'h304: n_mie_reg = csr_wdata[3:0];
`ifdef VECTORED_IRQ_EN
                12'h305: n_mtvec = csr_wdata & ~32'h2;
`else
                12'h305: n_mtvec = csr_wdata & ~32'h3;
`endif
                12'h341: n_mepc = csr_wdata & ~32'h3;
                12'h342: n_mcause = csr_wdata;
                default: ;
            endcase
        end
        pend = irq & m_mie_reg;
        if (m_busy) begin
            if (redirect_ready) n_busy = 1'b0;
        end else if (!pipe_flush) begin
            if (exc_valid) begin
                n_busy = 1'b1; n_tgt = m_mtvec & ~32'h3;
                n_mepc = exc_pc; n_mcause = 32'(exc_cause);
                n_mpie = m_mie; n_mie = 1'b0;
            end else if (mret) begin
                n_busy = 1'b1; n_tgt = m_mepc;
                n_mie = m_mpie; n_mpie = 1'b1;
            end else if (commit_valid && m_mie && pend != 4'd0) begin
                idx = 0;
                while (!pend[idx]) idx++;
                n_busy = 1'b1; n_mepc = commit_pc;
                n_mcause = 32'h8000_0000 | 32'(16 + idx);
                n_mpie = m_mie; n_mie = 1'b0;
                n_tgt = m_mtvec & ~32'h3;
`ifdef VECTORED_IRQ_EN
                if (m_mtvec[0]) n_tgt = n_tgt + 32'(4 * (16 + idx));
`endif
            end
        end
        m_busy = n_busy; m_tgt = n_tgt; m_mie = n_mie; m_mpie = n_mpie;
        m_mie_reg = n_mie_reg; m_mtvec = n_mtvec; m_mepc = n_mepc; m_mcause = n_mcause;
    endtask

    task automatic check_outputs();
        chk("redirect_valid", 32'(redirect_valid), 32'(m_busy));
        chk("trap_busy", 32'(trap_busy), 32'(m_busy));
        chk("redirect_target", redirect_target, m_tgt);
    endtask

    task automatic rd(input logic [11:0] a, input string tag, input logic [31:0] exp);
        csr_we = 1'b0; csr_addr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    task automatic check_csrs();
        rd(12'h300, "mstatus", (32'(m_mpie) << 7) | (32'(m_mie) << 3));
        rd(12'h304, "mie", 32'(m_mie_reg));
        rd(12'h305, "mtvec", m_mtvec);
        rd(12'h341, "mepc", m_mepc);
        rd(12'h342, "mcause", m_mcause);
        rd(12'h123, "unmapped", 32'h0);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        cycle();
        csr_we = 1'b0;
    endtask

    initial begin
        logic [31:0] sel;
        rst = 1'b1;
        redirect_ready = 1'b0;
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        check_csrs();
        rst = 1'b0;

        // exception to base
        csr_write(12'h305, 32'h100);
        exc_valid = 1; exc_cause = 5'd2; exc_pc = 32'h40;
        cycle();
        clear_inputs();
        chk("exc_valid_next", 32'(redirect_valid), 32'h1);
        chk("exc_target", redirect_target, 32'h100);
        rd(12'h341, "exc_mepc", 32'h40);
        rd(12'h342, "exc_mcause", 32'h2);
        redirect_ready = 1; cycle(); redirect_ready = 0;
        chk("exc_done", 32'(redirect_valid), 32'h0);

        // backpressure: ready low for three REDIRECT cycles
        exc_valid = 1; exc_cause = 5'd5; exc_pc = 32'h60;
        cycle();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin exc_valid = 1; exc_cause = 5'd9; exc_pc = 32'h999; end
            cycle();
            exc_valid = 0;
            chk("bp_valid", 32'(redirect_valid), 32'h1);
            chk("bp_target", redirect_target, 32'h100);
        end
        rd(12'h341, "bp_mepc", 32'h60);
        redirect_ready = 1; cycle();
        chk("bp_release", 32'(redirect_valid), 32'h0);

        // simultaneous exception, mret, interrupt and mepc write
        csr_write(12'h300, 32'h8);
        csr_write(12'h304, 32'hF);
        exc_valid = 1; exc_cause = 5'd7; exc_pc = 32'h1C0; mret = 1;
        irq = 4'b0001; commit_valid = 1; commit_pc = 32'h300;
        csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h500;
        cycle();
        clear_inputs();
        chk("sim_target", redirect_target, 32'h100);
        rd(12'h341, "sim_mepc", 32'h1C0);
        rd(12'h342, "sim_mcause", 32'h7);
        rd(12'h300, "sim_mstatus", 32'h80);
        cycle();

        // mret, then flushed exception
        csr_write(12'h341, 32'h44);
        redirect_ready = 0;
        mret = 1;
        cycle();
        clear_inputs();
        chk("mret_target", redirect_target, 32'h44);
        rd(12'h300, "mret_mstatus", 32'h88);
        redirect_ready = 1; cycle();
        pipe_flush = 1; exc_valid = 1; exc_pc = 32'h70;
        cycle();
        clear_inputs();
        chk("flush_no_redirect", 32'(redirect_valid), 32'h0);
        rd(12'h341, "flush_mepc", 32'h44);

        // interrupt, vectored when the feature is built in
        csr_write(12'h305, 32'h201);
        csr_write(12'h300, 32'h8);
        irq = 4'b0110; commit_valid = 1; commit_pc = 32'h80;
        cycle();
        clear_inputs();
`ifdef VECTORED_IRQ_EN
        chk("irq_target", redirect_target, 32'h244);
        rd(12'h305, "irq_mtvec", 32'h201);
`else
        chk("irq_target", redirect_target, 32'h200);
        rd(12'h305, "irq_mtvec", 32'h200);
`endif
        rd(12'h342, "irq_mcause", 32'h8000_0011);
        rd(12'h300, "irq_mstatus", 32'h80);
        rd(12'h341, "irq_mepc", 32'h80);
        cycle();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            pipe_flush     = ($urandom_range(0, 7) == 0);
            exc_valid      = ($urandom_range(0, 7) == 0);
            exc_cause      = 5'($urandom);
            exc_pc         = $urandom;
            mret           = ($urandom_range(0, 7) == 0);
            commit_valid   = ($urandom_range(0, 1) == 1);
            commit_pc      = $urandom;
            irq            = 4'($urandom);
            redirect_ready = ($urandom_range(0, 1) == 1);
            csr_we         = ($urandom_range(0, 3) == 0);
            sel            = $urandom_range(0, 5);
            case (sel)
                0: csr_addr = 12'h300;
                1: csr_addr = 12'h304;
                2: csr_addr = 12'h305;
                3: csr_addr = 12'h341;
                4: csr_addr = 12'h342;
                default: csr_addr = 12'h123;
            endcase
            csr_wdata = $urandom;
            cycle();
            check_csrs();
        end
        clear_inputs();

        // reset while redirecting
        redirect_ready = 0;
        cycle();
        cycle();
        csr_write(12'h305, 32'h400);
        exc_valid = 1; exc_cause = 5'd3; exc_pc = 32'h88;
        cycle();
        clear_inputs();
        chk("pre_rst_valid", 32'(redirect_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check_csrs();
        @(posedge clk);
        #1;
        chk("rst_edge_valid", 32'(redirect_valid), 32'h0);
        rst = 1'b0;
        cycle();
        check_csrs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
